tdm_demux4: RTL and testbench

//   Receive end of a 4-channel time-division link. Accepts one serial bit per valid beat

---
 rtl/tdm_demux4.sv | 129 ++++++++++++
 tb/tb_tdm_demux4.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux4
//  Purpose  : Receive end of a 4-channel TDM serial link. Tracks the slot
//             position from a frame-sync marker on slot 0 and rebuilds one
//             WIDTH-bit word per channel, MSB first, publishing all four
//             words together with a one-cycle out_valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic             out_valid,
  output logic             sync_err,
  output logic             locked
);

  localparam int               C_BCW      = $clog2(WIDTH);
  localparam logic [C_BCW-1:0] C_LAST_BIT = C_BCW'(WIDTH - 1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       slot_q;
  logic [C_BCW-1:0] bit_q;
  logic [WIDTH-1:0] sr_q  [4];
  logic [WIDTH-1:0] ch_q  [4];
  logic             out_valid_q;
  logic             sync_err_q;

  // Each channel's shift register with the current serial bit appended
  logic [WIDTH-1:0] w_shift [4];

  generate
    for (genvar k = 0; k < 4; k++) begin : g_shift
      assign w_shift[k] = {sr_q[k][WIDTH-2:0], din};
    end
  endgenerate

  // Slot tracking FSM, per-channel deserialisation and word publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      bit_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        sr_q[k] <= '0;
        ch_q[k] <= '0;
      end
    end else begin
      // Pulses last exactly one cycle unless re-asserted below
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            // Shift registers are already clear here, so this loads bit 0
            if (frame_sync) begin
              sr_q[0] <= w_shift[0];
              slot_q  <= 2'd1;
              bit_q   <= '0;
              state_q <= SYNC;
            end
          end

          SYNC: begin
            if ((slot_q == 2'd0) && !frame_sync) begin
              // Missing sync: drop the partial word and fall back to hunting
              sync_err_q <= 1'b1;
              for (int k = 0; k < 4; k++) sr_q[k] <= '0;
              bit_q   <= '0;
              slot_q  <= 2'd0;
              state_q <= HUNT;
            end else if ((slot_q != 2'd0) && frame_sync) begin
              // Early sync: drop the partial word, this beat restarts a word
              sync_err_q <= 1'b1;
              for (int k = 1; k < 4; k++) sr_q[k] <= '0;
              sr_q[0] <= {{(WIDTH-1){1'b0}}, din};
              bit_q   <= '0;
              slot_q  <= 2'd1;
            end else begin
              sr_q[slot_q] <= w_shift[slot_q];
              slot_q       <= slot_q + 2'd1;
              if (slot_q == 2'd3) begin
                if (bit_q == C_LAST_BIT) begin
                  // Channels 0..2 already hold their final bit; ch3 takes din now
                  ch_q[0]     <= sr_q[0];
                  ch_q[1]     <= sr_q[1];
                  ch_q[2]     <= sr_q[2];
                  ch_q[3]     <= w_shift[3];
                  out_valid_q <= 1'b1;
                  bit_q       <= '0;
                end else begin
                  bit_q <= bit_q + C_BCW'(1);
                end
              end
            end
          end

          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign ch0_data  = ch_q[0];
  assign ch1_data  = ch_q[1];
  assign ch2_data  = ch_q[2];
  assign ch3_data  = ch_q[3];
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == SYNC);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux4
//  Purpose  : Self-checking bench for tdm_demux4. Words are serialised from
//             their channel values; expected pulse positions and data follow
//             from frame arithmetic (4*W valid beats per word).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux4;

  localparam int W  = 8;
  localparam int FB = 4 * W;

  logic         clk;
  logic         rst_n;
  logic         din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         out_valid;
  logic         sync_err;
  logic         locked;

  int errors = 0;
  int checks = 0;

  // Observation log filled after every clock edge
  int           vbeat;
  int           lock_at;
  int           pulse_q[$];
  logic [FB-1:0] data_q[$];
  int           err_q[$];

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch0_data   (ch0),
    .ch1_data   (ch1),
    .ch2_data   (ch2),
    .ch3_data   (ch3),
    .out_valid  (out_valid),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required=1");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    vbeat   = 0;
    lock_at = 0;
    pulse_q.delete();
    data_q.delete();
    err_q.delete();
  endtask

  // One clock cycle: drive on the falling edge, observe 1 time unit after rising edge
  task automatic beat(input logic d, input logic fs, input logic v);
    @(negedge clk);
    din        = d;
    frame_sync = fs;
    din_valid  = v;
    @(posedge clk);
    #1;
    if (v) vbeat++;
    if (out_valid) begin
      pulse_q.push_back(vbeat);
      data_q.push_back({ch0, ch1, ch2, ch3});
    end
    if (sync_err) err_q.push_back(vbeat);
    if (locked && lock_at == 0) lock_at = vbeat;
  endtask

  task automatic idle(input int mode);
    int n;
    n = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int j = 0; j < n; j++) beat(1'($urandom), 1'($urandom), 1'b0);
  endtask

  // Serialise the first nbeats of word wd = {ch0,ch1,ch2,ch3}, sync on slot 0
  task automatic send_stream(input logic [FB-1:0] wd, input int nbeats, input int mode);
    int b;
    int k;
    for (int i = 0; i < nbeats; i++) begin
      b = i / 4;
      k = i % 4;
      beat(wd[(3 - k) * W + (W - 1 - b)], (k == 0), 1'b1);
      idle(mode);
    end
  endtask

  task automatic test_reset();
    logic [FB+2:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1'($urandom), 1'($urandom), 1'($urandom));
      obs = {ch0, ch1, ch2, ch3, out_valid, sync_err, locked};
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold: outputs=%h required=0", obs);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_basic();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL basic_unlocked: locked=%b required=0", locked);
    end
    send_stream(32'hA53C_0FF0, FB, 0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    checks++;
    if (pulse_q.size() !== 1 || pulse_q[0] !== FB) begin
      errors++;
      $display("FAIL basic_pulse: count=%0d first=%0d required count=1 at beat %0d",
               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1, FB);
    end
    checks++;
    if (data_q.size() < 1 || data_q[0] !== 32'hA53C_0FF0) begin
      errors++;
      $display("FAIL basic_data: got=%h required=a53c0ff0",
               (data_q.size() > 0) ? data_q[0] : '0);
    end
    checks++;
    if (lock_at !== 1) begin
      errors++;
      $display("FAIL basic_lock: locked first after beat %0d required 1", lock_at);
    end
    checks++;
    if (err_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_syncerr: count=%0d required 0", err_q.size());
    end
  endtask

  task automatic test_back_to_back_gaps();
    logic [FB-1:0] exp [2];
    exp[0] = 32'hA53C_0FF0;
    exp[1] = 32'h1234_5678;
    clear_mon();
    send_stream(exp[0], FB, 1);
    send_stream(exp[1], FB, 1);
    checks++;
    if (pulse_q.size() !== 2) begin
      errors++;
      $display("FAIL gaps_count: pulses=%0d required 2", pulse_q.size());
    end
    for (int i = 0; i < 2 && i < pulse_q.size(); i++) begin
      checks++;
      if (pulse_q[i] !== FB * (i + 1) || data_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL gaps_word%0d: beat=%0d data=%h required beat=%0d data=%h",
                 i, pulse_q[i], data_q[i], FB * (i + 1), exp[i]);
      end
    end
  endtask

  task automatic test_early_sync();
    logic [FB-1:0] wd;
    clear_mon();
    wd = 32'hC396_5AE1;
    send_stream(32'hFFFF_FFFF, 14, 0);
    send_stream(wd, FB, 0);
    checks++;
    if (err_q.size() !== 1 || err_q[0] !== 15) begin
      errors++;
      $display("FAIL early_err: count=%0d at=%0d required count=1 at beat 15",
               err_q.size(), (err_q.size() > 0) ? err_q[0] : -1);
    end
    checks++;
    if (pulse_q.size() !== 1 || pulse_q[0] !== 14 + FB || data_q[0] !== wd) begin
      errors++;
      $display("FAIL early_word: count=%0d beat=%0d data=%h required 1 at %0d data=%h",
               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1,
               (data_q.size() > 0) ? data_q[0] : '0, 14 + FB, wd);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL early_locked: locked=%b required 1", locked);
    end
  endtask

  task automatic test_missing_sync();
    logic [FB-1:0] wd;
    clear_mon();
    wd = 32'h0F1E_2D3C;
    send_stream(32'h5555_AAAA, 4, 0);
    beat(1'b1, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b0 || err_q.size() !== 1) begin
      errors++;
      $display("FAIL missing_err: locked=%b errs=%0d required locked=0 errs=1",
               locked, err_q.size());
    end
    for (int i = 0; i < 6; i++) beat(1'($urandom), 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b0 || pulse_q.size() !== 0) begin
      errors++;
      $display("FAIL missing_hunt: locked=%b pulses=%0d required 0 and 0",
               locked, pulse_q.size());
    end
    send_stream(wd, FB, 0);
    checks++;
    if (pulse_q.size() !== 1 || pulse_q[0] !== 11 + FB || data_q[0] !== wd) begin
      errors++;
      $display("FAIL missing_word: count=%0d beat=%0d data=%h required 1 at %0d data=%h",
               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1,
               (data_q.size() > 0) ? data_q[0] : '0, 11 + FB, wd);
    end
  endtask

  task automatic test_reset_midword();
    logic [FB-1:0] wd;
    logic [FB+2:0] obs;
    int b;
    int k;
    clear_mon();
    wd = 32'h9BAD_F00D;
    send_stream(wd, 17, 0);
    #1 rst_n = 1'b0;
    #1;
    obs = {ch0, ch1, ch2, ch3, out_valid, sync_err, locked};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h required 0 before next edge", obs);
    end
    #1 rst_n = 1'b1;
    for (int i = 17; i < FB; i++) begin
      b = i / 4;
      k = i % 4;
      beat(wd[(3 - k) * W + (W - 1 - b)], 1'b0, 1'b1);
    end
    checks++;
    if (pulse_q.size() !== 0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL resume_nosync: pulses=%0d locked=%b required 0 and 0",
               pulse_q.size(), locked);
    end
    send_stream(wd, FB, 0);
    checks++;
    if (pulse_q.size() !== 1 || pulse_q[0] !== 2 * FB || data_q[0] !== wd) begin
      errors++;
      $display("FAIL resume_word: count=%0d beat=%0d data=%h required 1 at %0d data=%h",
               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1,
               (data_q.size() > 0) ? data_q[0] : '0, 2 * FB, wd);
    end
  endtask

  task automatic test_random();
    logic [FB-1:0] exp [3];
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      exp[i] = FB'($urandom);
      send_stream(exp[i], FB, 2);
    end
    checks++;
    if (pulse_q.size() !== 3 || err_q.size() !== 0) begin
      errors++;
      $display("FAIL random_count: pulses=%0d errs=%0d required 3 and 0",
               pulse_q.size(), err_q.size());
    end
    for (int i = 0; i < 3 && i < pulse_q.size(); i++) begin
      checks++;
      if (pulse_q[i] !== FB * (i + 1) || data_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL random_word%0d: beat=%0d data=%h required beat=%0d data=%h",
                 i, pulse_q[i], data_q[i], FB * (i + 1), exp[i]);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_back_to_back_gaps();
    test_early_sync();
    test_missing_sync();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
